// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_stage
// Description : Instruction-fetch stage. Owns the fetch PC, picks the next
//               PC by fixed priority (EX branch > ROB redirect > predictor >
//               sequential PC+4), drives the I-cache address and presents
//               one packet to IF/ID when the cache returns data.
// Ports       : clk_i, rst_ni (async, active-low)
//               if_valid_i                 fetch enable (0 = stall)
//               certain_branch_pc_i/req_i  EX redirect (highest priority)
//               rob_target_pc_i/req_i      ROB redirect
//               branch_pred_pc_i/req_i     predictor target
//               icache_data_i/valid_i      cache data for current address
//               if_packet_*_o              {inst, PC, NPC, valid} to decode
//               proc2icache_addr_o         8-byte-aligned fetch address
//               req_debug_o/gnt_debug_o    raw request / one-hot grant
//               pc_reg_debug_o             current PC register
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_stage (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_valid_i,
    input  logic [31:0] certain_branch_pc_i,
    input  logic        certain_branch_req_i,
    input  logic [31:0] rob_target_pc_i,
    input  logic        rob_target_req_i,
    input  logic [31:0] branch_pred_pc_i,
    input  logic        branch_pred_req_i,
    input  logic [63:0] icache_data_i,
    input  logic        icache_data_valid_i,
    output logic [31:0] if_packet_inst_o,
    output logic [31:0] if_packet_pc_o,
    output logic [31:0] if_packet_npc_o,
    output logic        if_packet_valid_o,
    output logic [31:0] proc2icache_addr_o,
    output logic [3:0]  req_debug_o,
    output logic [3:0]  gnt_debug_o,
    output logic [31:0] pc_reg_debug_o
);

    localparam int          XLEN     = 32;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [0:0]  c_ISSUE  = 1'b0;
    localparam logic [0:0]  c_WAIT   = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            first_q, first_d;   // set until the first issue after reset

    logic [3:0]      w_req;
    logic [3:0]      w_gnt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_target;
    logic            w_issue;

    // Sequential request (bit0) is permanently asserted, so a grant always exists.
    assign w_req      = {certain_branch_req_i, rob_target_req_i, branch_pred_req_i, 1'b1};
    assign w_pc_plus4 = pc_q + 32'd4;
    // The very first fetch after reset uses the reset PC itself, not PC+4.
    assign w_seq_pc   = first_q ? pc_q : w_pc_plus4;
    assign w_issue    = (state_q == c_ISSUE) && if_valid_i;

    always_comb begin
        w_gnt    = 4'b0001;
        w_target = w_seq_pc;
        if (w_req[3]) begin
            w_gnt    = 4'b1000;
            w_target = certain_branch_pc_i;
        end else if (w_req[2]) begin
            w_gnt    = 4'b0100;
            w_target = rob_target_pc_i;
        end else if (w_req[1]) begin
            w_gnt    = 4'b0010;
            w_target = branch_pred_pc_i;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= c_ISSUE;
            pc_q    <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            first_q <= first_d;
        end
    end

    // Next-state logic; requests are only looked at on the issue edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        first_d = first_q;
        case (state_q)
            c_ISSUE: begin
                if (w_issue) begin
                    state_d = c_WAIT;
                    pc_d    = w_target;
                    first_d = 1'b0;
                end
            end
            c_WAIT: begin
                if (icache_data_valid_i && if_valid_i) begin
                    state_d = c_ISSUE;
                end
            end
            default: state_d = c_ISSUE;
        endcase
    end

    // Output logic
    always_comb begin
        if_packet_valid_o = (state_q == c_WAIT) && icache_data_valid_i && if_valid_i;
        if_packet_pc_o    = pc_q;
        if_packet_npc_o   = w_pc_plus4;
        if_packet_inst_o  = c_NOP;
        if (if_packet_valid_o) begin
            if_packet_inst_o = pc_q[2] ? icache_data_i[63:32] : icache_data_i[31:0];
        end
    end

    assign proc2icache_addr_o = {pc_q[XLEN-1:3], 3'b000};
    assign req_debug_o        = w_req;
    assign gnt_debug_o        = w_gnt;
    assign pc_reg_debug_o     = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_stage
// Description : Directed self-checking bench for ifetch_stage. Inputs change
//               on the falling edge; outputs are checked on the falling edge
//               (or 1 ns after an input change) away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_stage;

    localparam logic [63:0] c_LINE = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [31:0] c_LO   = 32'hCCCC_DDDD;
    localparam logic [31:0] c_HI   = 32'hAAAA_BBBB;
    localparam logic [31:0] c_NOP  = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_valid_i;
    logic [31:0] certain_branch_pc_i;
    logic        certain_branch_req_i;
    logic [31:0] rob_target_pc_i;
    logic        rob_target_req_i;
    logic [31:0] branch_pred_pc_i;
    logic        branch_pred_req_i;
    logic [63:0] icache_data_i;
    logic        icache_data_valid_i;
    logic [31:0] if_packet_inst_o;
    logic [31:0] if_packet_pc_o;
    logic [31:0] if_packet_npc_o;
    logic        if_packet_valid_o;
    logic [31:0] proc2icache_addr_o;
    logic [3:0]  req_debug_o;
    logic [3:0]  gnt_debug_o;
    logic [31:0] pc_reg_debug_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    ifetch_stage dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .if_valid_i           (if_valid_i),
        .certain_branch_pc_i  (certain_branch_pc_i),
        .certain_branch_req_i (certain_branch_req_i),
        .rob_target_pc_i      (rob_target_pc_i),
        .rob_target_req_i     (rob_target_req_i),
        .branch_pred_pc_i     (branch_pred_pc_i),
        .branch_pred_req_i    (branch_pred_req_i),
        .icache_data_i        (icache_data_i),
        .icache_data_valid_i  (icache_data_valid_i),
        .if_packet_inst_o     (if_packet_inst_o),
        .if_packet_pc_o       (if_packet_pc_o),
        .if_packet_npc_o      (if_packet_npc_o),
        .if_packet_valid_o    (if_packet_valid_o),
        .proc2icache_addr_o   (proc2icache_addr_o),
        .req_debug_o          (req_debug_o),
        .gnt_debug_o          (gnt_debug_o),
        .pc_reg_debug_o       (pc_reg_debug_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks a full valid packet at the current instant.
    task automatic check_pkt(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, ".valid"}, {63'd0, if_packet_valid_o}, 64'd1);
        check({tag, ".pc"},    {32'd0, if_packet_pc_o},    {32'd0, pc});
        check({tag, ".npc"},   {32'd0, if_packet_npc_o},   {32'd0, pc + 32'd4});
        check({tag, ".inst"},  {32'd0, if_packet_inst_o},  {32'd0, inst});
    endtask

    initial begin
        rst_ni               = 1'b0;
        if_valid_i           = 1'b0;
        certain_branch_pc_i  = 32'h0;
        certain_branch_req_i = 1'b0;
        rob_target_pc_i      = 32'h0;
        rob_target_req_i     = 1'b0;
        branch_pred_pc_i     = 32'h0;
        branch_pred_req_i    = 1'b0;
        icache_data_i        = c_LINE;
        icache_data_valid_i  = 1'b0;

        // Reset state
        @(negedge clk_i);
        check("rst.valid", {63'd0, if_packet_valid_o}, 64'd0);
        check("rst.pc",    {32'd0, pc_reg_debug_o},    64'd0);
        check("rst.addr",  {32'd0, proc2icache_addr_o}, 64'd0);
        check("rst.gnt",   {60'd0, gnt_debug_o},       64'h1);
        check("rst.inst",  {32'd0, if_packet_inst_o},  {32'd0, c_NOP});

        // All three requests: EX branch wins
        rst_ni               = 1'b1;
        if_valid_i           = 1'b1;
        certain_branch_pc_i  = 32'h1111; certain_branch_req_i = 1'b1;
        rob_target_pc_i      = 32'h2222; rob_target_req_i     = 1'b1;
        branch_pred_pc_i     = 32'h3333; branch_pred_req_i    = 1'b1;
        #1;
        check("all.req", {60'd0, req_debug_o}, 64'hF);
        check("all.gnt", {60'd0, gnt_debug_o}, 64'h8);
        @(negedge clk_i);
        check("wait.nodata", {63'd0, if_packet_valid_o}, 64'd0);
        check("wait.pcreg",  {32'd0, pc_reg_debug_o},    64'h1111);
        check("wait.addr",   {32'd0, proc2icache_addr_o}, 64'h1110);
        icache_data_valid_i = 1'b1; #1;
        check_pkt("p1111", 32'h1111, c_LO);

        // Changed EX target is taken on the next issue
        certain_branch_pc_i = 32'h1221;
        @(negedge clk_i);
        check("issue.gap", {63'd0, if_packet_valid_o}, 64'd0);
        icache_data_valid_i = 1'b0;
        @(negedge clk_i);
        icache_data_valid_i = 1'b1; #1;
        check_pkt("p1221", 32'h1221, c_LO);

        // EX request dropped: ROB wins
        certain_branch_req_i = 1'b0;
        @(negedge clk_i);
        check("rob.gnt", {60'd0, gnt_debug_o}, 64'h4);
        icache_data_valid_i = 1'b0;
        @(negedge clk_i);
        icache_data_valid_i = 1'b1; #1;
        check_pkt("p2222", 32'h2222, c_LO);

        // Predictor only, to 0x2000
        rob_target_req_i = 1'b0;
        branch_pred_pc_i = 32'h2000;
        @(negedge clk_i);
        check("pred.gnt", {60'd0, gnt_debug_o}, 64'h2);
        icache_data_valid_i = 1'b0;
        @(negedge clk_i);
        icache_data_valid_i = 1'b1; #1;
        check_pkt("p2000", 32'h2000, c_LO);
        check("p2000.addr", {32'd0, proc2icache_addr_o}, 64'h2000);

        // No requests: sequential fetch
        branch_pred_req_i = 1'b0;
        @(negedge clk_i);
        check("seq.gnt", {60'd0, gnt_debug_o}, 64'h1);
        icache_data_valid_i = 1'b0;
        @(negedge clk_i);
        check("p2004.addr", {32'd0, proc2icache_addr_o}, 64'h2000);
        icache_data_valid_i = 1'b1; #1;
        check_pkt("p2004", 32'h2004, c_HI);
        @(negedge clk_i);
        icache_data_valid_i = 1'b0;
        @(negedge clk_i);
        check("p2008.addr", {32'd0, proc2icache_addr_o}, 64'h2008);

        // Stall in WAIT with data valid: no packet, PC held
        icache_data_valid_i = 1'b1;
        if_valid_i          = 1'b0; #1;
        check("stall.valid0", {63'd0, if_packet_valid_o}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall.valid", {63'd0, if_packet_valid_o}, 64'd0);
            check("stall.pcreg", {32'd0, pc_reg_debug_o},    64'h2008);
        end
        if_valid_i = 1'b1; #1;
        check_pkt("p2008", 32'h2008, c_LO);

        // Reset mid-WAIT takes effect without a clock edge
        @(negedge clk_i);
        icache_data_valid_i = 1'b0;
        @(negedge clk_i);
        check("p200c.pcreg", {32'd0, pc_reg_debug_o}, 64'h200C);
        icache_data_valid_i = 1'b1; #1;
        check("pre_rst.valid", {63'd0, if_packet_valid_o}, 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        check("arst.valid", {63'd0, if_packet_valid_o}, 64'd0);
        check("arst.pcreg", {32'd0, pc_reg_debug_o},    64'd0);
        check("arst.addr",  {32'd0, proc2icache_addr_o}, 64'd0);

        // PC+4 wraps modulo 2^32
        @(negedge clk_i);
        icache_data_valid_i = 1'b0;
        rst_ni              = 1'b1;
        branch_pred_pc_i    = 32'hFFFF_FFFC;
        branch_pred_req_i   = 1'b1;
        @(negedge clk_i);
        icache_data_valid_i = 1'b1; #1;
        check_pkt("pwrap", 32'hFFFF_FFFC, c_HI);
        branch_pred_req_i = 1'b0;
        @(negedge clk_i);
        icache_data_valid_i = 1'b0;
        @(negedge clk_i);
        check("wrap.pcreg", {32'd0, pc_reg_debug_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the out-of-order RISC-V core (`ifetch` module). It owns the fetch PC register, chooses the next fetch PC by fixed priority among execute-resolved branches, ROB redirects, the branch predictor and sequential PC+4, and drives the address to the instruction cache. When the cache returns data it presents one decoded-stage packet to IF/ID.

## Interface
Parameters: none. `XLEN` (32) and `IF_ID_PACKET` come from `sys_defs.svh`.
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low
- if_valid  in  1  fetch enable; 0 = stall (no issue, no packet)
- certain_branch_pc  in  XLEN  resolved taken-branch target from EX
- certain_branch_req  in  1  EX redirect request (highest priority)
- rob_target_pc  in  XLEN  ROB redirect target
- rob_target_req  in  1  ROB redirect request (second priority)
- branch_pred_pc  in  XLEN  predicted target
- branch_pred_req  in  1  predictor request (third priority)
- Icache2proc_data  in  64  cache line word for current address
- Icache2proc_data_valid  in  1  cache data valid for current proc2Icache_addr
- if_packet  out  IF_ID_PACKET  {inst, PC, NPC, valid} to decode
- proc2Icache_addr  out  XLEN  8-byte-aligned fetch address
- req_debug  out  4  raw request vector
- gnt_debug  out  4  one-hot grant vector
- PC_reg_debug  out  XLEN  current PC register

## Operation
- Request vector: req_debug = {certain_branch_req, rob_target_req, branch_pred_req, 1'b1}; bit0 (PC+4) is always requesting.
- Fixed-priority grant (bit3 highest): gnt_debug is one-hot, valid every cycle. Selected target: bit3 certain_branch_pc, bit2 rob_target_pc, bit1 branch_pred_pc, bit0 PC_reg+4 (except first issue after reset: PC_reg, i.e. 0).
- Two-state FSM: ISSUE, WAIT.
  - ISSUE: if if_valid, PC_reg <= selected target, go WAIT. If if_valid=0, hold state and PC.
  - WAIT: requests ignored (upstream holds requests until consumed). When Icache2proc_data_valid && if_valid: if_packet.valid=1 this cycle, next state ISSUE. Otherwise stay in WAIT.
- proc2Icache_addr = {PC_reg[XLEN-1:3], 3'b000}.
- if_packet.inst = PC_reg[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0]; if_packet.PC = PC_reg; if_packet.NPC = PC_reg+4. When valid=0, inst = `NOP.
- PC alignment is not checked; low bits pass through to packet PC unchanged.
- PC+4 wraps modulo 2^XLEN.

## Timing
- Reset (asserted low, async): PC_reg=0, state=ISSUE, first-issue flag set, if_packet.valid=0, proc2Icache_addr=0.
- if_packet is combinational from state, PC_reg and cache outputs; valid is a single-cycle pulse per fetch, always followed by at least one cycle of valid=0 (the ISSUE cycle).
- Fetch latency: 1 ISSUE cycle + cache hit/miss latency; minimum 2 cycles between packets.
- Requests are sampled only at the ISSUE clock edge; a request changing during WAIT affects the next issue.
- Simultaneous requests: highest-priority wins; lower ones are dropped, not queued.
- if_valid low in WAIT: no packet; fetch completes when if_valid returns and data is valid.
- Reset mid-fetch: abandon in-flight fetch, return to reset state immediately.

## Test plan
- Reset then all three requests high (certain=0x1111, rob=0x2222, pred=0x3333) -> first packet PC=0x1111, NPC=0x1115, valid pulse; gnt_debug=4'b1000.
- Keep certain_branch_req, change target to 0x1221 after first packet -> next packet PC=0x1221.
- Drop certain_branch_req (rob, pred still high) -> next packet PC=0x2222, gnt_debug=4'b0100.
- No requests after fetch at 0x2000 -> subsequent packets 0x2004, 0x2008; inst from upper/lower half per PC[2]; proc2Icache_addr 0x2000 then 0x2008.
- if_valid=0 for 5 cycles during WAIT with cache data valid -> no packet, PC_reg held; packet appears the cycle if_valid returns.
- Assert reset low mid-WAIT -> if_packet.valid=0 and PC_reg_debug=0 immediately, without waiting for a clock edge.
